// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle processor.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath enables and the 4-bit alu_op consumed by ALUControl.
// Memory accesses stall in FETCH, MEM_RD and MEM_WR until mem_ready.
// Optional feature macro: BRANCH_EXT_EN (adds bgt/bge/blt/ble branches).
// Handshake: mem_ready is sampled in FETCH, MEM_RD and MEM_WR only; the
// state advances on the first rising edge that sees it high, and every
// output stays constant while it is low.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [3:0]         alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef BRANCH_EXT_EN
    localparam logic [5:0] OP_BGT  = 6'b010000;
    localparam logic [5:0] OP_BGE  = 6'b010001;
    localparam logic [5:0] OP_BLT  = 6'b010010;
    localparam logic [5:0] OP_BLE  = 6'b010011;
`endif

    logic [3:0] state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;

    // Next-state logic; the opcode is captured only while in DECODE
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:               state_d = S_MEM_ADDR;
                    OP_R:                       state_d = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:             state_d = S_BRANCH;
`ifdef BRANCH_EXT_EN
                    OP_BGT, OP_BGE, OP_BLT, OP_BLE: state_d = S_BRANCH;
`endif
                    OP_J:                       state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, latched opcode and illegal pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= 6'b000000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    logic [3:0] imm_alu_op;
    logic [3:0] branch_alu_op;

    // ALU operation for immediate arithmetic and branch compares, from opcode_q
    always_comb begin
        imm_alu_op    = 4'b0001;
        branch_alu_op = 4'b0100;
        case (opcode_q)
            OP_ANDI: imm_alu_op = 4'b0010;
            OP_ORI:  imm_alu_op = 4'b0011;
            default: imm_alu_op = 4'b0001;
        endcase
        case (opcode_q)
            OP_BNE:  branch_alu_op = 4'b0101;
`ifdef BRANCH_EXT_EN
            OP_BGT:  branch_alu_op = 4'b0110;
            OP_BGE:  branch_alu_op = 4'b0111;
            OP_BLT:  branch_alu_op = 4'b1000;
            OP_BLE:  branch_alu_op = 4'b1001;
`endif
            default: branch_alu_op = 4'b0100;
        endcase
    end

    // Moore output decode; everything is forced low while reset is asserted
    // so that an in-flight write is cut off immediately
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 4'b0001;
        illegal       = illegal_q;
        state         = STATE_W'(state_q);
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 4'b0000;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = 4'b0000;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op;
            end
            S_I_WB: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                alu_op        = branch_alu_op;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_op        = 4'b0000;
            illegal       = 1'b0;
            state         = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-instruction reference traces are
// queued by the driver and compared cycle by cycle by a separate monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic [3:0] state;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal(illegal), .state(state)
    );

    // Clock
    always #5 clk = ~clk;

    // Observed output vector: state, ten enables, srcb, pcsrc, alu_op, illegal
    logic [22:0] dut_vec;
    assign dut_vec = {state, pc_write, pc_write_cond, iord, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                      alu_src_b, pc_source, alu_op, illegal};

    logic [22:0] exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    bit  pending_ill = 1'b0;

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (state got=%0d exp=%0d) t=%0t",
                     name, got, exp, got[22:19], exp[22:19], $time);
        end
    endtask

    // Reference: instruction class from the opcode map
    // 0 illegal, 1 lw, 2 sw, 3 R, 4 I-type, 5 branch, 6 jump
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return 3;
            6'b001000, 6'b001100, 6'b001101: return 4;
            6'b000100, 6'b000101: return 5;
`ifdef BRANCH_EXT_EN
            6'b010000, 6'b010001, 6'b010010, 6'b010011: return 5;
`endif
            6'b000010: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] branch_code(input logic [5:0] op);
        case (op)
            6'b000100: return 4'd4;
            6'b000101: return 4'd5;
            6'b010000: return 4'd6;
            6'b010001: return 4'd7;
            6'b010010: return 4'd8;
            6'b010011: return 4'd9;
            default:   return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] imm_code(input logic [5:0] op);
        case (op)
            6'b001100: return 4'd2;
            6'b001101: return 4'd3;
            default:   return 4'd1;
        endcase
    endfunction

    // Reference: expected outputs of one cycle in a given state
    function automatic logic [22:0] exp_out(input int st, input logic [5:0] op,
                                            input logic mr, input logic ill);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] ao;
        {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; ao = 4'b0001;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; ao = 4'b0000; end
            7:  begin rw = 1; rd = 1; ao = 4'b0000; end
            8:  begin sa = 1; pwc = 1; ps = 2'b01; ao = branch_code(op); end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ao = imm_code(op); end
            11: begin sa = 1; sb = 2'b10; ao = imm_code(op); rw = 1; end
            default: ;
        endcase
        return {4'(st), pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ps, ao, ill};
    endfunction

    // Driver: build the state walk for one instruction, queue its expected
    // trace, then drive opcode/mem_ready for each of its cycles
    task automatic issue(input logic [5:0] op, input int fstall, input int mstall,
                         input logic [5:0] junk, input bit rand_junk);
        int st_seq[$];
        logic mr_seq[$];
        int cls;
        cls = op_class(op);
        repeat (fstall) begin st_seq.push_back(0); mr_seq.push_back(1'b0); end
        st_seq.push_back(0); mr_seq.push_back(1'b1);
        st_seq.push_back(1); mr_seq.push_back(1'($urandom));
        case (cls)
            1: begin
                st_seq.push_back(2); mr_seq.push_back(1'($urandom));
                repeat (mstall) begin st_seq.push_back(3); mr_seq.push_back(1'b0); end
                st_seq.push_back(3); mr_seq.push_back(1'b1);
                st_seq.push_back(4); mr_seq.push_back(1'($urandom));
            end
            2: begin
                st_seq.push_back(2); mr_seq.push_back(1'($urandom));
                repeat (mstall) begin st_seq.push_back(5); mr_seq.push_back(1'b0); end
                st_seq.push_back(5); mr_seq.push_back(1'b1);
            end
            3: begin
                st_seq.push_back(6); mr_seq.push_back(1'($urandom));
                st_seq.push_back(7); mr_seq.push_back(1'($urandom));
            end
            4: begin
                st_seq.push_back(10); mr_seq.push_back(1'($urandom));
                st_seq.push_back(11); mr_seq.push_back(1'($urandom));
            end
            5: begin st_seq.push_back(8); mr_seq.push_back(1'($urandom)); end
            6: begin st_seq.push_back(9); mr_seq.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < st_seq.size(); i++)
            exp_q.push_back(exp_out(st_seq[i], op, mr_seq[i], (i == 0) && pending_ill));
        pending_ill = (cls == 0);
        for (int i = 0; i < st_seq.size(); i++) begin
            if (st_seq[i] == 1) opcode = op;
            else opcode = rand_junk ? 6'($urandom) : junk;
            mem_ready = mr_seq[i];
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop and compare one expected vector every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("trace_underflow", dut_vec, ~dut_vec);
            end else begin
                check("trace", dut_vec, exp_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    logic [5:0] legal_ops [13] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                   6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                   6'b000010, 6'b010000, 6'b010001, 6'b010010,
                                   6'b010011};

    // Stimulus sequence
    initial begin
        logic [5:0] op;
        rst_n = 1'b0;
        opcode = 6'b100011;
        mem_ready = 1'b1;
        #3;
        check("reset_outputs", dut_vec, 23'd0);
        #9;
        rst_n = 1'b1;
        // walk a sw into MEM_WR and stall there
        opcode = 6'b000000; mem_ready = 1'b1;
        @(posedge clk); #1;
        opcode = 6'b101011;
        @(posedge clk); #1;
        opcode = 6'b111111;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("mem_wr_before_reset", dut_vec, exp_out(5, 6'b101011, 1'b0, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        check("mem_wr_cut_by_reset", dut_vec, 23'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("fetch_after_reset", dut_vec, exp_out(0, 6'b000000, 1'b0, 1'b0));

        mon_en = 1'b1;
        issue(6'b000000, 0, 0, 6'b101011, 1'b0);   // R-type
        issue(6'b100011, 0, 2, 6'b000000, 1'b0);   // lw with two read stalls
        issue(6'b010011, 0, 0, 6'b000000, 1'b0);   // ble
        issue(6'b001101, 0, 0, 6'b111111, 1'b0);   // ori, opcode junk after decode
        issue(6'b111111, 0, 0, 6'b000000, 1'b0);   // unmapped
        issue(6'b101011, 1, 1, 6'b000000, 1'b1);   // sw with stalls
        issue(6'b000010, 0, 0, 6'b000000, 1'b1);   // j
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 12)];
            issue(op, $urandom_range(0, 2), $urandom_range(0, 2), 6'd0, 1'b1);
        end
        issue(6'b000100, 0, 0, 6'd0, 1'b1);        // flushes any pending illegal pulse
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL trace_leftover: %0d entries remain, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
